// File: rtl/multi_dataflow_engine.sv
// Streaming 3-tap horizontal running-sum engine over a width x height frame,
// with a 2-entry first-word-fall-through output buffer absorbing sink backpressure.
module multi_dataflow_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int DIM_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_mode_i,
   input  logic                  clear_i,
   input  logic                  ctrl_clear_i,
   input  logic                  ctrl_enable_i,
   input  logic                  ctrl_start_i,
   input  logic [CNT_WIDTH-1:0]  ctrl_cnt_limit_i,
   input  logic [DIM_WIDTH-1:0]  ctrl_width_i,
   input  logic [DIM_WIDTH-1:0]  ctrl_height_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [CNT_WIDTH-1:0]  flags_cnt_o,
   output logic                  flags_ready_o,
   output logic                  flags_done_o
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                state;
   logic [DIM_WIDTH-1:0]  width_q, height_q, col, row;
   logic [CNT_WIDTH-1:0]  cnt_limit_q;
   logic [DATA_WIDTH-1:0] tap1, tap2, sum;
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            fifo_count;
   logic                  clr, in_fire, out_fire, last_col, last_in;
   logic                  unused_bits;

   assign clr         = clear_i | ctrl_clear_i;
   // Clear outranks every handshake, so ready is withheld in the clearing cycle.
   assign in_ready_o  = (state == RUN) & ctrl_enable_i & (fifo_count != 2'd2) & ~clr;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_valid_o = (fifo_count != 2'd0);
   assign out_fire    = out_valid_o & out_ready_i;
   assign out_data_o  = mem[rd_ptr];
   assign sum         = in_data_i + tap1 + tap2;
   assign last_col    = (col == width_q - DIM_WIDTH'(1));
   assign last_in     = last_col && (row == height_q - DIM_WIDTH'(1));
   // The limit is held for the controller's benefit only; test mode has no effect.
   assign unused_bits = ^{test_mode_i, cnt_limit_q};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         width_q       <= '0;
         height_q      <= '0;
         cnt_limit_q   <= '0;
         col           <= '0;
         row           <= '0;
         tap1          <= '0;
         tap2          <= '0;
         flags_ready_o <= 1'b1;
         flags_done_o  <= 1'b0;
      end else if (clr) begin
         state         <= IDLE;
         width_q       <= '0;
         height_q      <= '0;
         cnt_limit_q   <= '0;
         col           <= '0;
         row           <= '0;
         tap1          <= '0;
         tap2          <= '0;
         flags_ready_o <= 1'b1;
         flags_done_o  <= 1'b0;
      end else begin
         flags_done_o <= 1'b0;
         case (state)
            IDLE: if (ctrl_start_i) begin
               width_q       <= ctrl_width_i;
               height_q      <= ctrl_height_i;
               cnt_limit_q   <= ctrl_cnt_limit_i;
               col           <= '0;
               row           <= '0;
               tap1          <= '0;
               tap2          <= '0;
               flags_ready_o <= 1'b0;
               state         <= (ctrl_width_i == '0 || ctrl_height_i == '0) ? DONE : RUN;
            end
            RUN: if (in_fire) begin
               if (last_col) begin
                  col  <= '0;
                  row  <= row + DIM_WIDTH'(1);
                  tap1 <= '0;
                  tap2 <= '0;
               end else begin
                  col  <= col + DIM_WIDTH'(1);
                  tap1 <= in_data_i;
                  tap2 <= tap1;
               end
               if (last_in) state <= FLUSH;
            end
            FLUSH: if (fifo_count == 2'd0) state <= DONE;
            DONE: begin
               flags_done_o  <= 1'b1;
               flags_ready_o <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the two buffer entries are reset so out_data_o reads 0 after
   // reset or clear; larger buffers would normally be left unreset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else if (clr) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (in_fire) begin
            mem[wr_ptr] <= sum;
            wr_ptr      <= ~wr_ptr;
         end
         if (out_fire) rd_ptr <= ~rd_ptr;
         case ({in_fire, out_fire})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flags_cnt_o <= '0;
      end else if (clr) begin
         flags_cnt_o <= '0;
      end else if (out_fire && flags_cnt_o != '1) begin
         flags_cnt_o <= flags_cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_multi_dataflow_engine.sv
// Self-checking bench: directed frames plus randomized frames, scored against a
// queue-based model of the running-sum kernel and the 2-deep output buffer.
module tb_multi_dataflow_engine;

   localparam int DW = 32;
   localparam int CW = 16;
   localparam int WW = 16;
   localparam logic [DW-1:0] EXP_A [8] = '{32'd1, 32'd3, 32'd6, 32'd9, 32'd5, 32'd11, 32'd18, 32'd21};
   localparam logic [DW-1:0] EXP_C [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                           32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

   logic          clk_i = 1'b0;
   logic          rst_ni, test_mode_i, clear_i, ctrl_clear_i, ctrl_enable_i, ctrl_start_i;
   logic [CW-1:0] ctrl_cnt_limit_i;
   logic [WW-1:0] ctrl_width_i, ctrl_height_i;
   logic [DW-1:0] in_data_i, out_data_o;
   logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [CW-1:0] flags_cnt_o;
   logic          flags_ready_o, flags_done_o;

   multi_dataflow_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .DIM_WIDTH(WW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
      .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i), .ctrl_start_i(ctrl_start_i),
      .ctrl_cnt_limit_i(ctrl_cnt_limit_i), .ctrl_width_i(ctrl_width_i), .ctrl_height_i(ctrl_height_i),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .flags_cnt_o(flags_cnt_o), .flags_ready_o(flags_ready_o), .flags_done_o(flags_done_o)
   );

   always #5 clk_i = ~clk_i;

   int            n_checks, n_fail, n_done, n_acc_dut, src_idx;
   logic [DW-1:0] src[$], hist[$], exp_q[$], got[$];
   bit            m_run;
   int            m_w, m_h, m_acc;
   logic [CW-1:0] m_cnt;
   bit            rand_rdy, rand_val, rand_en, rand_start;
   logic          obs_done, obs_ready, obs_in_ready, obs_valid;
   logic [DW-1:0] obs_data;
   logic [CW-1:0] obs_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0;
      m_acc = 0;
      m_cnt = '0;
      hist.delete();
      exp_q.delete();
   endtask

   // One clock: sample and score at the falling edge, update the model, then
   // drive the next inputs just after the rising edge.
   task automatic cycle();
      bit            exp_rdy, in_fire, out_fire;
      int            c;
      logic [DW-1:0] s;
      @(negedge clk_i);
      obs_done     = flags_done_o;
      obs_ready    = flags_ready_o;
      obs_in_ready = in_ready_o;
      obs_valid    = out_valid_o;
      obs_data     = out_data_o;
      obs_cnt      = flags_cnt_o;
      if (flags_done_o) n_done++;
      if (in_valid_i && in_ready_o) n_acc_dut++;
      exp_rdy = rst_ni && m_run && ctrl_enable_i && (exp_q.size() < 2) && !clear_i && !ctrl_clear_i;
      check("in_ready", in_ready_o, exp_rdy);
      check("out_valid", out_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) check("out_data", out_data_o, exp_q[0]);
      check("flags_cnt", flags_cnt_o, m_cnt);
      in_fire  = in_valid_i && exp_rdy;
      out_fire = out_ready_i && (exp_q.size() != 0);
      if (!rst_ni || clear_i || ctrl_clear_i) begin
         model_reset();
      end else begin
         if (ctrl_start_i && !m_run) begin
            hist.delete();
            m_acc = 0;
            if (ctrl_width_i != 0 && ctrl_height_i != 0) begin
               m_run = 1'b1;
               m_w   = int'(ctrl_width_i);
               m_h   = int'(ctrl_height_i);
            end
         end
         if (out_fire) begin
            got.push_back(out_data_o);
            void'(exp_q.pop_front());
            if (m_cnt != '1) m_cnt++;
         end
         if (in_fire) begin
            c = m_acc % m_w;
            s = in_data_i;
            if (c >= 1) s += hist[m_acc-1];
            if (c >= 2) s += hist[m_acc-2];
            hist.push_back(in_data_i);
            exp_q.push_back(s);
            m_acc++;
            src_idx++;
            if (m_acc == m_w * m_h) m_run = 1'b0;
         end
      end
      @(posedge clk_i);
      #1;
      if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
      if (rand_en) ctrl_enable_i = ($urandom_range(0, 4) != 0);
      if (rand_start) begin
         ctrl_start_i  = m_run && ($urandom_range(0, 7) == 0);
         ctrl_width_i  = WW'($urandom_range(0, 7));
         ctrl_height_i = WW'($urandom_range(0, 7));
      end
      if (src_idx < src.size()) begin
         in_data_i  = src[src_idx];
         in_valid_i = !rand_val || ($urandom_range(0, 3) != 0);
      end else begin
         in_data_i  = $urandom;
         in_valid_i = 1'b0;
      end
   endtask

   task automatic load_src(input int n, input logic [DW-1:0] first, input bit rnd);
      src.delete();
      src_idx = 0;
      for (int i = 0; i < n; i++) src.push_back(rnd ? DW'($urandom) : first + DW'(i));
      in_data_i  = src[0];
      in_valid_i = 1'b1;
   endtask

   task automatic start_frame(input int w, input int h);
      ctrl_width_i     = WW'(w);
      ctrl_height_i    = WW'(h);
      ctrl_cnt_limit_i = CW'(w * h);
      ctrl_start_i     = 1'b1;
      got.delete();
      cycle();
      ctrl_start_i = 1'b0;
   endtask

   task automatic do_clear();
      ctrl_clear_i = 1'b1;
      cycle();
      ctrl_clear_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!obs_done && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_done_seen"}, obs_done, 1'b1);
   endtask

   task automatic wait_accepted(input int target, input int budget);
      int n = 0;
      while (n_acc_dut < target && n < budget) begin
         cycle();
         n++;
      end
      check("accept_bound", n_acc_dut, target);
   endtask

   task automatic check_seq(input string tag, input logic [DW-1:0] ev [8], input int n);
      check({tag, "_len"}, got.size(), n);
      for (int i = 0; i < n; i++) if (i < got.size()) check(tag, got[i], ev[i]);
   endtask

   // Finish a frame: one done pulse, then idle with ready high.
   task automatic finish_frame(input string tag, input int nd0, input int budget);
      wait_done(tag, budget);
      cycle();
      check({tag, "_done_once"}, n_done, nd0 + 1);
      check({tag, "_done_low"}, obs_done, 1'b0);
      check({tag, "_ready"}, obs_ready, 1'b1);
   endtask

   initial begin
      int nd0, acc0, w, h;
      n_checks = 0; n_fail = 0; n_done = 0; n_acc_dut = 0; src_idx = 0;
      rand_rdy = 0; rand_val = 0; rand_en = 0; rand_start = 0;
      rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; ctrl_clear_i = 1'b0;
      ctrl_enable_i = 1'b1; ctrl_start_i = 1'b0; ctrl_cnt_limit_i = '0;
      ctrl_width_i = '0; ctrl_height_i = '0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      obs_done = 1'b0;
      model_reset();
      repeat (3) cycle();
      rst_ni = 1'b1;
      cycle();
      check("rst_ready", obs_ready, 1'b1);
      check("rst_done", obs_done, 1'b0);
      check("rst_data", obs_data, 32'd0);
      check("rst_valid", obs_valid, 1'b0);
      check("rst_cnt", obs_cnt, 16'd0);

      // 4x2 frame, free-flowing sink
      load_src(8, 32'd1, 1'b0);
      nd0 = n_done;
      start_frame(4, 2);
      finish_frame("a", nd0, 100);
      check_seq("a_seq", EXP_A, 8);
      check("a_cnt", obs_cnt, 16'd8);

      // Same frame with the sink stalled for 6 cycles after start
      do_clear();
      load_src(8, 32'd1, 1'b0);
      out_ready_i = 1'b0;
      acc0 = n_acc_dut;
      nd0  = n_done;
      start_frame(4, 2);
      repeat (6) cycle();
      check("b_accepted", n_acc_dut - acc0, 2);
      check("b_in_ready", obs_in_ready, 1'b0);
      check("b_hold_data", obs_data, 32'd1);
      out_ready_i = 1'b1;
      finish_frame("b", nd0, 100);
      check_seq("b_seq", EXP_A, 8);

      // 3x1 frame exercising wrap-around
      do_clear();
      src.delete();
      for (int i = 0; i < 3; i++) src.push_back(32'hFFFF_FFFF);
      src_idx = 0;
      nd0 = n_done;
      start_frame(3, 1);
      finish_frame("c", nd0, 100);
      check_seq("c_seq", EXP_C, 3);

      // Zero width: no input, done two cycles after start
      do_clear();
      load_src(4, 32'd7, 1'b1);
      acc0 = n_acc_dut;
      start_frame(0, 5);
      cycle();
      check("d_done_early", obs_done, 1'b0);
      cycle();
      check("d_done", obs_done, 1'b1);
      check("d_accepted", n_acc_dut - acc0, 0);
      check("d_valid", obs_valid, 1'b0);
      check("d_cnt", obs_cnt, 16'd0);
      src.delete();
      src_idx = 0;
      cycle();

      // Enable gap mid-row
      do_clear();
      load_src(8, 32'd1, 1'b0);
      nd0 = n_done;
      start_frame(4, 2);
      repeat (2) cycle();
      ctrl_enable_i = 1'b0;
      repeat (3) begin
         cycle();
         check("e_gap_ready", obs_in_ready, 1'b0);
      end
      ctrl_enable_i = 1'b1;
      finish_frame("e", nd0, 100);
      check_seq("e_seq", EXP_A, 8);

      // Clear after 3 inputs, then restart
      do_clear();
      load_src(8, 32'd1, 1'b0);
      acc0 = n_acc_dut;
      start_frame(4, 2);
      wait_accepted(acc0 + 3, 30);
      do_clear();
      cycle();
      check("f_clr_ready", obs_ready, 1'b1);
      check("f_clr_valid", obs_valid, 1'b0);
      check("f_clr_cnt", obs_cnt, 16'd0);
      load_src(8, 32'd1, 1'b0);
      nd0 = n_done;
      start_frame(4, 2);
      finish_frame("f", nd0, 100);
      check_seq("f_seq", EXP_A, 8);

      // Asynchronous reset after 5 inputs, then restart
      load_src(8, 32'd1, 1'b0);
      acc0 = n_acc_dut;
      start_frame(4, 2);
      wait_accepted(acc0 + 5, 30);
      rst_ni = 1'b0;
      model_reset();
      cycle();
      check("g_rst_ready", obs_ready, 1'b1);
      check("g_rst_valid", obs_valid, 1'b0);
      check("g_rst_cnt", obs_cnt, 16'd0);
      rst_ni = 1'b1;
      load_src(8, 32'd1, 1'b0);
      nd0 = n_done;
      start_frame(4, 2);
      finish_frame("g", nd0, 100);
      check_seq("g_seq", EXP_A, 8);

      // Randomized frames with stalls, enable gaps and ignored mid-run starts
      test_mode_i = 1'b1;
      for (int f = 0; f < 8; f++) begin
         w = $urandom_range(1, 6);
         h = $urandom_range(1, 4);
         load_src(w * h, 32'd0, 1'b1);
         rand_rdy = 1; rand_val = 1; rand_en = 1; rand_start = 1;
         nd0 = n_done;
         start_frame(w, h);
         wait_done("r", 600);
         rand_rdy = 0; rand_val = 0; rand_en = 0; rand_start = 0;
         ctrl_start_i = 1'b0; ctrl_enable_i = 1'b1; out_ready_i = 1'b1;
         cycle();
         check("r_done_once", n_done, nd0 + 1);
         check("r_len", got.size(), w * h);
         check("r_ready", obs_ready, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
